obi_xbar: RTL and testbench
===========================

Name: obi_xbar

Overview:
- Parametrised OBI crossbar; successor to the fixed 2x2 obi_interconnect between the core's I/D ports and rom/ram/peripherals.
- Adds per-slave round-robin arbitration with grant locking and multiple outstanding transactions per slave.
- Adds per-master in-order response routing and a decode-error responder for unmapped addresses.

Parameters:
- MASTERS, 2, number of master ports (1..8)
- SLAVES, 2, number of slave ports (1..16)
- OUTSTANDING, 2, max in-flight transactions per slave and per master (power of 2, >=1)
- AW, 32, address width
- DW, 32, data width (byte enables DW/8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- master_req_i  in  MASTERS x 1  address-phase request
- master_gnt_o  out  MASTERS x 1  address-phase grant
- master_rvalid_o  out  MASTERS x 1  response valid
- master_err_o  out  MASTERS x 1  response error (decode miss)
- master_we_i  in  MASTERS x 1  write enable
- master_be_i  in  MASTERS x DW/8  byte enables
- master_addr_i  in  MASTERS x AW  address
- master_wdata_i  in  MASTERS x DW  write data
- master_rdata_o  out  MASTERS x DW  read data
- slave_addr_mask_i  in  SLAVES x AW  region mask
- slave_addr_base_i  in  SLAVES x AW  region base
- slave_req_o / slave_gnt_i / slave_rvalid_i  out/in/in  SLAVES x 1  OBI handshake
- slave_we_o / slave_be_o / slave_addr_o / slave_wdata_o  out  SLAVES x 1/DW/8/AW/DW  muxed request
- slave_rdata_i  in  SLAVES x DW  read data

Behaviour:
- Reset: all gnt/rvalid/err/slave_req outputs 0, rdata 0; FIFOs empty, counters 0, RR pointers 0, locks clear.
- Decode: slave s hits when (addr & mask[s]) == base[s]. On multiple hits the lowest s wins; no hit targets the internal error responder (target index SLAVES).
- Master eligibility: master m may present to target t only if outstanding[m]==0 or last_target[m]==t, and outstanding[m] < OUTSTANDING. Ineligible masters see gnt=0 and stall; this preserves per-master response order.
- Arbitration per slave: round-robin among eligible requesters, starting at ptr[s]. When slave_req_o is high and slave_gnt_i is low, the chosen master is locked until its handshake, so the request stays stable per OBI. On handshake (req&gnt), ptr[s] = winner+1 mod MASTERS and the lock clears.
- slave_req_o = a winner exists AND the slave route FIFO is not full. Request fields are muxed from the winner. master_gnt_o[winner] = slave_gnt_i & slave_req_o; 0 latency added.
- Route FIFO per slave (depth OUTSTANDING) stores the winner index on handshake and is popped on slave_rvalid_i. The response is routed to the head master: rvalid=1, rdata=slave_rdata_i, err=0, same cycle. Push and pop in the same cycle are allowed, count unchanged. slave_rvalid_i with an empty FIFO is ignored (assertion in bench).
- Error responder: grants eligible misses immediately, one master per cycle, round-robin. Responds exactly 1 cycle later with rvalid=1, err=1, rdata=0.
- Per-master outstanding counter: +1 on handshake, -1 on rvalid, both in one cycle = no change. last_target updates on handshake.
- Reset mid-transaction discards all in-flight state; responses arriving after reset deassertion with empty FIFOs are dropped.

Decomposition:
- obi_xbar_pkg: clog2-derived index widths, TGT_ERR constant, typedefs obi_req_t {we,be,addr,wdata} and obi_rsp_t {rdata,err}.
- One sub-module: obi_rr_arbiter (N requesters, pointer, lock, one-hot grant, index out), instantiated SLAVES+1 times.
- Route FIFOs are a small generic sync FIFO (existing, or inline counters).

Test Plan:
- M0 and M1 both request slave1 every cycle, slave gnt=1, rvalid next cycle -> grants alternate M0,M1,M0,M1; each master sees rvalid with its own rdata.
- M0 requests slave0 with slave gnt held 0 for 3 cycles while M1 (higher priority after pointer) raises req -> slave_addr_o stays M0 address until grant; M1 granted next.
- OUTSTANDING=2, slave0 delays rvalid by 4 cycles, M0 issues 3 back-to-back -> first 2 granted, 3rd stalls until first rvalid, then granted the same cycle.
- M0 reads slave0 (pending), then requests slave1 -> no gnt until slave0 response returns; then slave1 granted; responses arrive in issue order.
- M1 reads addr 0xDEAD_0000 (no hit) -> gnt same cycle, next cycle rvalid=1, err=1, rdata=0x0; no slave_req_o asserted.
- Assert rst_i with 2 transactions in flight -> all outputs 0 next edge; after release, a new M0 read completes normally with counters starting at 0.

Source files
------------

// File: rtl/obi_xbar_pkg.sv
// Shared helpers for the OBI crossbar: index-width derivation and the
// reserved target index that selects the internal decode-error responder.
package obi_xbar_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Target index one past the last real slave routes to the error responder.
  function automatic int unsigned tgt_err(input int unsigned slaves);
    return slaves;
  endfunction

endpackage

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter with a grant lock that holds the chosen requester
// stable while its OBI address phase waits for the slave's grant.
module obi_rr_arbiter
  import obi_xbar_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          hold_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_idx_q;
  logic          locked_q;
  logic [IW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    gnt_o   = '0;
    cand    = '0;
    if (locked_q) begin
      idx_o   = lock_idx_q;
      valid_o = req_i[lock_idx_q];
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        cand = IW'((32'(ptr_q) + i) % N);
        if (!valid_o && req_i[cand]) begin
          valid_o = 1'b1;
          idx_o   = cand;
        end
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
    end else if (adv_i) begin
      ptr_q    <= (32'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
      locked_q <= 1'b0;
    end else if (hold_i && valid_o) begin
      locked_q   <= 1'b1;
      lock_idx_q <= idx_o;
    end
  end

endmodule

// File: rtl/obi_xbar.sv
// Parametrised OBI crossbar: per-slave round-robin arbitration, per-slave
// route FIFOs for in-order responses, and a decode-error responder.
module obi_xbar
  import obi_xbar_pkg::*;
#(
  parameter int unsigned MASTERS     = 2,
  parameter int unsigned SLAVES      = 2,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [MASTERS-1:0]               master_req_i,
  output logic [MASTERS-1:0]               master_gnt_o,
  output logic [MASTERS-1:0]               master_rvalid_o,
  output logic [MASTERS-1:0]               master_err_o,
  input  logic [MASTERS-1:0]               master_we_i,
  input  logic [MASTERS-1:0][DW/8-1:0]     master_be_i,
  input  logic [MASTERS-1:0][AW-1:0]       master_addr_i,
  input  logic [MASTERS-1:0][DW-1:0]       master_wdata_i,
  output logic [MASTERS-1:0][DW-1:0]       master_rdata_o,
  input  logic [SLAVES-1:0][AW-1:0]        slave_addr_mask_i,
  input  logic [SLAVES-1:0][AW-1:0]        slave_addr_base_i,
  output logic [SLAVES-1:0]                slave_req_o,
  input  logic [SLAVES-1:0]                slave_gnt_i,
  input  logic [SLAVES-1:0]                slave_rvalid_i,
  output logic [SLAVES-1:0]                slave_we_o,
  output logic [SLAVES-1:0][DW/8-1:0]      slave_be_o,
  output logic [SLAVES-1:0][AW-1:0]        slave_addr_o,
  output logic [SLAVES-1:0][DW-1:0]        slave_wdata_o,
  input  logic [SLAVES-1:0][DW-1:0]        slave_rdata_i
);

  localparam int unsigned MW      = idx_w(MASTERS);
  localparam int unsigned TW      = idx_w(SLAVES + 1);
  localparam int unsigned TGT_ERR = tgt_err(SLAVES);
  localparam int unsigned CW      = $clog2(OUTSTANDING + 1);
  localparam int unsigned PW      = idx_w(OUTSTANDING);
  localparam int unsigned BW      = DW / 8;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } obi_rsp_t;

  obi_req_t [MASTERS-1:0]          mreq;
  obi_rsp_t [MASTERS-1:0]          mrsp;
  logic [MASTERS-1:0][TW-1:0]      tgt;
  logic [MASTERS-1:0]              elig;
  logic [MASTERS-1:0][CW-1:0]      out_cnt_q;
  logic [MASTERS-1:0][TW-1:0]      last_tgt_q;
  logic [SLAVES:0][MASTERS-1:0]    treq;
  logic [SLAVES:0][MASTERS-1:0]    arb_gnt;
  logic [SLAVES:0][MW-1:0]         arb_idx;
  logic [SLAVES:0]                 arb_valid;
  logic [SLAVES:0]                 arb_hold;
  logic [SLAVES:0]                 arb_adv;
  logic [SLAVES-1:0]               fifo_full;
  logic [SLAVES-1:0]               pop;
  logic [SLAVES-1:0][MW-1:0]       head;
  logic                            err_valid_q;
  logic [MW-1:0]                   err_idx_q;

  // Decode walks downward so the lowest matching slave wins. A response
  // returning this cycle frees a slot for the same master immediately.
  always_comb begin
    tgt  = '0;
    mreq = '0;
    elig = '0;
    treq = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      tgt[m] = TW'(TGT_ERR);
      for (int unsigned s = SLAVES; s > 0; s--) begin
        if ((master_addr_i[m] & slave_addr_mask_i[s-1]) == slave_addr_base_i[s-1])
          tgt[m] = TW'(s - 1);
      end
      mreq[m] = '{we: master_we_i[m], be: master_be_i[m],
                  addr: master_addr_i[m], wdata: master_wdata_i[m]};
      elig[m] = !rst_i && master_req_i[m]
              && (out_cnt_q[m] == '0 || last_tgt_q[m] == tgt[m])
              && (32'(out_cnt_q[m]) < OUTSTANDING || master_rvalid_o[m]);
      for (int unsigned t = 0; t <= SLAVES; t++)
        treq[t][m] = elig[m] && (32'(tgt[m]) == t);
    end
  end

  for (genvar t = 0; t <= SLAVES; t++) begin : g_arb
    obi_rr_arbiter #(.N(MASTERS)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (treq[t]),
      .hold_i  (arb_hold[t]),
      .adv_i   (arb_adv[t]),
      .gnt_o   (arb_gnt[t]),
      .idx_o   (arb_idx[t]),
      .valid_o (arb_valid[t])
    );
  end

  always_comb begin
    slave_req_o   = '0;
    slave_we_o    = '0;
    slave_be_o    = '0;
    slave_addr_o  = '0;
    slave_wdata_o = '0;
    arb_hold      = '0;
    arb_adv       = '0;
    master_gnt_o  = '0;
    for (int unsigned s = 0; s < SLAVES; s++) begin
      slave_req_o[s]   = arb_valid[s] && !fifo_full[s];
      slave_we_o[s]    = mreq[arb_idx[s]].we;
      slave_be_o[s]    = mreq[arb_idx[s]].be;
      slave_addr_o[s]  = mreq[arb_idx[s]].addr;
      slave_wdata_o[s] = mreq[arb_idx[s]].wdata;
      arb_hold[s]      = slave_req_o[s] && !slave_gnt_i[s];
      arb_adv[s]       = slave_req_o[s] && slave_gnt_i[s];
    end
    arb_adv[SLAVES] = arb_valid[SLAVES];
    for (int unsigned m = 0; m < MASTERS; m++) begin
      for (int unsigned t = 0; t <= SLAVES; t++)
        master_gnt_o[m] = master_gnt_o[m] | (arb_adv[t] & arb_gnt[t][m]);
    end
  end

  always_comb begin
    master_rvalid_o = '0;
    mrsp            = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      for (int unsigned s = 0; s < SLAVES; s++) begin
        if (pop[s] && head[s] == MW'(m)) begin
          master_rvalid_o[m] = 1'b1;
          mrsp[m].rdata      = slave_rdata_i[s];
        end
      end
      if (err_valid_q && err_idx_q == MW'(m)) begin
        master_rvalid_o[m] = 1'b1;
        mrsp[m].err        = 1'b1;
      end
      master_rdata_o[m] = mrsp[m].rdata;
      master_err_o[m]   = mrsp[m].err;
    end
  end

  for (genvar s = 0; s < SLAVES; s++) begin : g_route
    logic [OUTSTANDING-1:0][MW-1:0] mem_q;
    logic [PW-1:0]                  wr_q;
    logic [PW-1:0]                  rd_q;
    logic [CW-1:0]                  cnt_q;

    assign pop[s]       = slave_rvalid_i[s] && cnt_q != '0;
    assign head[s]      = mem_q[rd_q];
    assign fifo_full[s] = (32'(cnt_q) == OUTSTANDING) && !pop[s];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mem_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (arb_adv[s]) begin
          mem_q[wr_q] <= arb_idx[s];
          wr_q        <= (32'(wr_q) == OUTSTANDING - 1) ? '0 : wr_q + 1'b1;
        end
        if (pop[s])
          rd_q <= (32'(rd_q) == OUTSTANDING - 1) ? '0 : rd_q + 1'b1;
        if (arb_adv[s] && !pop[s])
          cnt_q <= cnt_q + 1'b1;
        else if (!arb_adv[s] && pop[s])
          cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q   <= '0;
      last_tgt_q  <= '0;
      err_valid_q <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (master_gnt_o[m] && !master_rvalid_o[m])
          out_cnt_q[m] <= out_cnt_q[m] + 1'b1;
        else if (!master_gnt_o[m] && master_rvalid_o[m])
          out_cnt_q[m] <= out_cnt_q[m] - 1'b1;
        if (master_gnt_o[m])
          last_tgt_q[m] <= tgt[m];
      end
      err_valid_q <= arb_adv[SLAVES];
      err_idx_q   <= arb_idx[SLAVES];
    end
  end

endmodule

// File: tb/tb_obi_xbar.sv
// Directed bench for obi_xbar with behavioural slaves and a per-master
// response scoreboard filled at grant time from the bench's own address map.
module tb_obi_xbar;

  localparam int unsigned MASTERS     = 2;
  localparam int unsigned SLAVES      = 2;
  localparam int unsigned OUTSTANDING = 2;
  localparam int unsigned AW          = 32;
  localparam int unsigned DW          = 32;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [MASTERS-1:0]            master_req_i;
  logic [MASTERS-1:0]            master_gnt_o;
  logic [MASTERS-1:0]            master_rvalid_o;
  logic [MASTERS-1:0]            master_err_o;
  logic [MASTERS-1:0]            master_we_i;
  logic [MASTERS-1:0][DW/8-1:0]  master_be_i;
  logic [MASTERS-1:0][AW-1:0]    master_addr_i;
  logic [MASTERS-1:0][DW-1:0]    master_wdata_i;
  logic [MASTERS-1:0][DW-1:0]    master_rdata_o;
  logic [SLAVES-1:0][AW-1:0]     slave_addr_mask_i;
  logic [SLAVES-1:0][AW-1:0]     slave_addr_base_i;
  logic [SLAVES-1:0]             slave_req_o;
  logic [SLAVES-1:0]             slave_gnt_i;
  logic [SLAVES-1:0]             slave_rvalid_i = '0;
  logic [SLAVES-1:0]             slave_we_o;
  logic [SLAVES-1:0][DW/8-1:0]   slave_be_o;
  logic [SLAVES-1:0][AW-1:0]     slave_addr_o;
  logic [SLAVES-1:0][DW-1:0]     slave_wdata_o;
  logic [SLAVES-1:0][DW-1:0]     slave_rdata_i = '0;

  typedef struct { int unsigned due; logic [31:0] data; } pend_t;
  typedef struct { logic [31:0] rdata; logic err; } exp_t;

  pend_t       pend [SLAVES][$];
  exp_t        sb   [MASTERS][$];
  int unsigned lat  [SLAVES];
  int unsigned cyc   = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  obi_xbar #(
    .MASTERS(MASTERS), .SLAVES(SLAVES), .OUTSTANDING(OUTSTANDING), .AW(AW), .DW(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .master_req_i(master_req_i), .master_gnt_o(master_gnt_o),
    .master_rvalid_o(master_rvalid_o), .master_err_o(master_err_o),
    .master_we_i(master_we_i), .master_be_i(master_be_i),
    .master_addr_i(master_addr_i), .master_wdata_i(master_wdata_i),
    .master_rdata_o(master_rdata_o),
    .slave_addr_mask_i(slave_addr_mask_i), .slave_addr_base_i(slave_addr_base_i),
    .slave_req_o(slave_req_o), .slave_gnt_i(slave_gnt_i), .slave_rvalid_i(slave_rvalid_i),
    .slave_we_o(slave_we_o), .slave_be_o(slave_be_o), .slave_addr_o(slave_addr_o),
    .slave_wdata_o(slave_wdata_o), .slave_rdata_i(slave_rdata_i)
  );

  function automatic int unsigned ref_tgt(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
    if ((a & 32'hFFFF_0000) == 32'h0001_0000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] slv_data(input int unsigned s, input logic [31:0] a);
    return a ^ (32'h5A5A_0000 + 32'(s));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Slave models: accept on handshake, answer in order after lat[s] cycles.
  always @(negedge clk) begin
    for (int s = 0; s < SLAVES; s++) begin
      if (slave_rvalid_i[s]) void'(pend[s].pop_front());
      if (slave_req_o[s] && slave_gnt_i[s])
        pend[s].push_back('{cyc + lat[s], slv_data(s, slave_addr_o[s])});
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int s = 0; s < SLAVES; s++) begin
      if (pend[s].size() != 0 && pend[s][0].due <= cyc) begin
        slave_rvalid_i[s] = 1'b1;
        slave_rdata_i[s]  = pend[s][0].data;
      end else begin
        slave_rvalid_i[s] = 1'b0;
        slave_rdata_i[s]  = '0;
      end
    end
  end

  // Scoreboard: pop on response, push the bench-derived expectation on grant.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < MASTERS; m++) begin
        if (master_rvalid_o[m]) begin
          if (sb[m].size() == 0) begin
            chk($sformatf("m%0d_unexpected_rvalid", m), 64'(master_rvalid_o[m]), 64'd0);
          end else begin
            exp_t e;
            e = sb[m].pop_front();
            chk($sformatf("m%0d_rdata", m), 64'(master_rdata_o[m]), 64'(e.rdata));
            chk($sformatf("m%0d_err", m), 64'(master_err_o[m]), 64'(e.err));
          end
        end
        if (master_gnt_o[m]) begin
          int unsigned t;
          t = ref_tgt(master_addr_i[m]);
          sb[m].push_back('{(t == 2) ? 32'h0 : slv_data(t, master_addr_i[m]), t == 2});
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    master_req_i      = '0;
    master_we_i       = '0;
    master_be_i       = '0;
    master_addr_i     = '0;
    master_wdata_i    = '0;
    slave_gnt_i       = '1;
    lat[0]            = 1;
    lat[1]            = 1;
    slave_addr_mask_i = {32'hFFFF_0000, 32'hFFFF_0000};
    slave_addr_base_i = {32'h0001_0000, 32'h0000_0000};

    repeat (2) mid();
    chk("rst_gnt", 64'(master_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(master_rvalid_o), 64'd0);
    chk("rst_err", 64'(master_err_o), 64'd0);
    chk("rst_sreq", 64'(slave_req_o), 64'd0);
    chk("rst_rdata", 64'(master_rdata_o), 64'd0);
    step(); rst = 1'b0;

    // Both masters contend for slave1: grants alternate.
    step(); master_req_i = 2'b11;
    master_addr_i[0] = 32'h0001_0010; master_addr_i[1] = 32'h0001_0020;
    mid(); chk("rr_gnt0", 64'(master_gnt_o), 64'b01);
    step(); mid(); chk("rr_gnt1", 64'(master_gnt_o), 64'b10); chk("rr_rv1", 64'(master_rvalid_o), 64'b01);
    step(); mid(); chk("rr_gnt2", 64'(master_gnt_o), 64'b01); chk("rr_rv2", 64'(master_rvalid_o), 64'b10);
    step(); mid(); chk("rr_gnt3", 64'(master_gnt_o), 64'b10); chk("rr_rv3", 64'(master_rvalid_o), 64'b01);
    step(); master_req_i = '0;
    mid(); chk("rr_gnt_idle", 64'(master_gnt_o), 64'd0); chk("rr_rv4", 64'(master_rvalid_o), 64'b10);

    // Move slave0 pointer to M1, then check M0 stays locked while waiting.
    step(); master_req_i[0] = 1'b1; master_addr_i[0] = 32'h0000_0080;
    mid(); chk("pre_gnt", 64'(master_gnt_o), 64'b01);
    step(); master_req_i[0] = 1'b0;
    mid(); chk("pre_rv", 64'(master_rvalid_o), 64'b01);
    step(); slave_gnt_i[0] = 1'b0; master_req_i[0] = 1'b1; master_addr_i[0] = 32'h0000_0100;
    master_we_i[0] = 1'b1; master_be_i[0] = 4'h3; master_wdata_i[0] = 32'h1111_2222;
    mid(); chk("lock_sreq", 64'(slave_req_o[0]), 64'd1);
    chk("lock_addr0", 64'(slave_addr_o[0]), 64'h100); chk("lock_gnt0", 64'(master_gnt_o), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step(); master_req_i[1] = 1'b1; master_addr_i[1] = 32'h0000_0200;
      mid(); chk("lock_addr", 64'(slave_addr_o[0]), 64'h100); chk("lock_gnt", 64'(master_gnt_o), 64'd0);
    end
    step(); slave_gnt_i[0] = 1'b1;
    mid(); chk("lock_rel_gnt", 64'(master_gnt_o), 64'b01); chk("lock_rel_addr", 64'(slave_addr_o[0]), 64'h100);
    chk("lock_we", 64'(slave_we_o[0]), 64'd1); chk("lock_be", 64'(slave_be_o[0]), 64'h3);
    chk("lock_wdata", 64'(slave_wdata_o[0]), 64'h1111_2222);
    step(); master_req_i[0] = 1'b0; master_we_i[0] = 1'b0;
    mid(); chk("lock_next_gnt", 64'(master_gnt_o), 64'b10); chk("lock_next_addr", 64'(slave_addr_o[0]), 64'h200);
    step(); master_req_i[1] = 1'b0; mid();
    step(); mid();

    // Outstanding limit: third request stalls until the first response.
    step(); lat[0] = 4; master_req_i[0] = 1'b1; master_addr_i[0] = 32'h0000_0300;
    mid(); chk("os_gnt0", 64'(master_gnt_o), 64'b01);
    step(); master_addr_i[0] = 32'h0000_0304;
    mid(); chk("os_gnt1", 64'(master_gnt_o), 64'b01);
    step(); master_addr_i[0] = 32'h0000_0308;
    mid(); chk("os_stall_gnt", 64'(master_gnt_o), 64'd0); chk("os_stall_sreq", 64'(slave_req_o), 64'd0);
    step(); mid(); chk("os_stall_gnt2", 64'(master_gnt_o), 64'd0);
    step(); mid(); chk("os_rv0", 64'(master_rvalid_o), 64'b01); chk("os_gnt2", 64'(master_gnt_o), 64'b01);
    step(); master_req_i[0] = 1'b0;
    mid(); chk("os_rv1", 64'(master_rvalid_o), 64'b01);
    repeat (2) begin step(); mid(); end
    step(); mid(); chk("os_rv2", 64'(master_rvalid_o), 64'b01);

    // Target switch waits until the pending slave0 response returns.
    step(); master_req_i[0] = 1'b1; master_addr_i[0] = 32'h0000_0400;
    mid(); chk("sw_gnt0", 64'(master_gnt_o), 64'b01);
    step(); master_addr_i[0] = 32'h0001_0040;
    mid(); chk("sw_block", 64'(master_gnt_o), 64'd0); chk("sw_sreq", 64'(slave_req_o), 64'd0);
    repeat (2) begin step(); mid(); chk("sw_block", 64'(master_gnt_o), 64'd0); end
    step(); mid(); chk("sw_rv0", 64'(master_rvalid_o), 64'b01); chk("sw_block_rv", 64'(master_gnt_o), 64'd0);
    step(); mid(); chk("sw_gnt1", 64'(master_gnt_o), 64'b01);
    step(); master_req_i[0] = 1'b0;
    mid(); chk("sw_rv1", 64'(master_rvalid_o), 64'b01);

    // Unmapped address: immediate grant, error one cycle later.
    step(); master_req_i[1] = 1'b1; master_addr_i[1] = 32'hDEAD_0000;
    mid(); chk("de_gnt", 64'(master_gnt_o), 64'b10); chk("de_sreq", 64'(slave_req_o), 64'd0);
    step(); master_req_i[1] = 1'b0;
    mid(); chk("de_rv", 64'(master_rvalid_o), 64'b10); chk("de_err", 64'(master_err_o), 64'b10);
    chk("de_rdata", 64'(master_rdata_o[1]), 64'd0);

    // Reset with transactions in flight; late responses must be dropped.
    step(); lat[0] = 4; lat[1] = 4; master_req_i = 2'b11;
    master_addr_i[0] = 32'h0000_0500; master_addr_i[1] = 32'h0001_0500;
    mid(); chk("mr_gnt", 64'(master_gnt_o), 64'b11);
    step(); master_req_i = '0; rst = 1'b1; sb[0].delete(); sb[1].delete();
    mid(); chk("mr_gnt_rst", 64'(master_gnt_o), 64'd0); chk("mr_rv_rst", 64'(master_rvalid_o), 64'd0);
    chk("mr_err_rst", 64'(master_err_o), 64'd0); chk("mr_sreq_rst", 64'(slave_req_o), 64'd0);
    step(); rst = 1'b0; lat[0] = 1; lat[1] = 1; mid();
    repeat (4) begin step(); mid(); chk("mr_drop", 64'(master_rvalid_o), 64'd0); end
    step(); master_req_i[0] = 1'b1; master_addr_i[0] = 32'h0001_0600;
    mid(); chk("mr_new_gnt", 64'(master_gnt_o), 64'b01);
    step(); master_req_i[0] = 1'b0;
    mid(); chk("mr_new_rv", 64'(master_rvalid_o), 64'b01);
    chk("mr_new_rdata", 64'(master_rdata_o[0]), 64'(slv_data(1, 32'h0001_0600)));
    step(); mid();
    chk("sb_m0_empty", 64'(sb[0].size()), 64'd0);
    chk("sb_m1_empty", 64'(sb[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
